// File: rtl/enc_pkg.sv
// Shared constants, FSM state type and popcount helper for the 8-to-3 scanning encoder.
package enc_pkg;

  localparam int WIDTH = 8;
  localparam int AW    = 3;

  typedef enum logic {
    IDLE = 1'b0,
    EMIT = 1'b1
  } state_t;

  // Number of set bits in a WIDTH-bit vector; result fits in AW+1 bits (0..8).
  function automatic logic [AW:0] popcount(input logic [WIDTH-1:0] v);
    logic [AW:0] cnt;
    cnt = '0;
    for (int i = 0; i < WIDTH; i++) begin
      cnt = cnt + (AW+1)'(v[i]);
    end
    return cnt;
  endfunction

endpackage

// File: rtl/pri_enc8.sv
// Combinational lowest-set-bit finder: bit 0 has the highest priority.
module pri_enc8
  import enc_pkg::*;
(
  input  logic [WIDTH-1:0] in,
  output logic [AW-1:0]    idx,
  output logic             zero,
  output logic             single
);

  // any_below[k] is set when some bit below position k is set.
  logic [WIDTH:0]   any_below;
  logic [WIDTH-1:0] first;

  assign any_below[0] = 1'b0;

  generate
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_prefix
      assign any_below[gi+1] = any_below[gi] | in[gi];
      // One-hot marker of the lowest set bit.
      assign first[gi] = in[gi] & ~any_below[gi];
    end
  endgenerate

  // Binary-encode the one-hot lowest-bit marker.
  always_comb begin
    idx = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (first[i]) begin
        idx = idx | AW'(i);
      end
    end
  end

  assign zero   = ~any_below[WIDTH];
  // Clearing the lowest set bit leaves nothing when exactly one bit was set.
  assign single = ~zero & ((in & (in - WIDTH'(1))) == '0);

endmodule

// File: rtl/enc8to3_scan.sv
// Sequential 8-to-3 encoder: accepts a vector, then emits the index of each
// set bit, lowest first, one beat per handshake. An all-zero vector yields a
// single beat flagged with out_none.
module enc8to3_scan
  import enc_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] in,
  input  logic             in_vld,
  output logic             in_rdy,
  output logic [AW-1:0]    out,
  output logic             out_vld,
  input  logic             out_rdy,
  output logic             out_last,
  output logic             out_none,
  output logic [AW:0]      ones
);

  state_t           state_reg, state_next;
  logic [WIDTH-1:0] pend_reg, pend_next;
  logic [AW:0]      ones_reg, ones_next;

  logic [AW-1:0] low_idx;
  logic          pend_zero;
  logic          pend_single;
  logic          emitting;
  logic          accept;
  logic          beat;

  pri_enc8 u_pri (
    .in     (pend_reg),
    .idx    (low_idx),
    .zero   (pend_zero),
    .single (pend_single)
  );

  assign emitting = (state_reg == EMIT);

  // Output beat and handshake decode; the in_rdy path through out_rdy lets a
  // new vector load on the same edge as the last beat, so no idle bubble.
  always_comb begin
    out_vld  = emitting;
    out      = emitting ? low_idx : '0;
    out_last = emitting & (pend_zero | pend_single);
    out_none = emitting & pend_zero;
    in_rdy   = ~emitting | (out_last & out_rdy);
    accept   = in_vld & in_rdy;
    beat     = emitting & out_rdy;
  end

  // Next-state: a new accept wins over the last-beat return to IDLE.
  always_comb begin
    state_next = state_reg;
    pend_next  = pend_reg;
    ones_next  = ones_reg;
    if (accept) begin
      state_next = EMIT;
      pend_next  = in;
      ones_next  = popcount(in);
    end else if (beat) begin
      pend_next = pend_reg & (pend_reg - WIDTH'(1));
      if (out_last) begin
        state_next = IDLE;
      end
    end
  end

  // State, pending vector and popcount registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      pend_reg  <= '0;
      ones_reg  <= '0;
    end else begin
      state_reg <= state_next;
      pend_reg  <= pend_next;
      ones_reg  <= ones_next;
    end
  end

  assign ones = ones_reg;

endmodule
